// File: rtl/aes_cmd_sched.sv
// Command sequencer for the AES core: key-expansion caching, one-cycle core starts, result hand-off.
// Optional wait-state timeout is enabled with `define AES_CMD_SCHED_TIMEOUT_EN.
module aes_cmd_sched #(
  parameter int unsigned KEY_W          = 128,
  parameter int unsigned BLK_W          = 128,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [1:0]       s_cmd,
  input  logic [KEY_W-1:0] s_key,
  input  logic [BLK_W-1:0] s_blk,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [BLK_W-1:0] m_blk,
  output logic [1:0]       m_status,
  output logic             aes_en,
  output logic             aes_cipher_mode,
  output logic             aes_decipher_mode,
  output logic             aes_key_exp_mode,
  output logic [KEY_W-1:0] aes_key,
  output logic [BLK_W-1:0] aes_in_blk,
  input  logic [BLK_W-1:0] aes_out_blk,
  input  logic             aes_en_o,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE,
    KEY_GO,
    KEY_WAIT,
    DATA_GO,
    DATA_WAIT,
    OUT
  } state_t;

  localparam logic [1:0] CMD_ENC = 2'b00;
  localparam logic [1:0] CMD_DEC = 2'b01;
  localparam logic [1:0] CMD_KEY = 2'b10;
  localparam logic [1:0] CMD_RSV = 2'b11;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_BAD = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;

  state_t             state, state_nxt;
  logic [1:0]         cmd_q;
  logic [KEY_W-1:0]   key_q;
  logic [KEY_W-1:0]   cached_key;
  logic               key_valid;
  logic [BLK_W-1:0]   blk_q;
  logic [BLK_W-1:0]   res_q;
  logic [1:0]         status_q;
  logic               accept;
  logic               need_key;
  logic               in_wait;
  logic               tmo;

  assign accept   = s_valid && s_ready;
  assign need_key = !key_valid || (s_key != cached_key);
  assign in_wait  = (state == KEY_WAIT) || (state == DATA_WAIT);

`ifdef AES_CMD_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;

  // Cleared in the GO cycle so the first WAIT cycle sees zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if ((state == KEY_GO) || (state == DATA_GO)) begin
      wait_cnt <= '0;
    end else if (in_wait) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign tmo = in_wait && !aes_en_o && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (s_cmd == CMD_RSV) begin
            state_nxt = OUT;
          end else if ((s_cmd == CMD_KEY) || need_key) begin
            state_nxt = KEY_GO;
          end else begin
            state_nxt = DATA_GO;
          end
        end
      end
      KEY_GO:  state_nxt = KEY_WAIT;
      KEY_WAIT: begin
        if (aes_en_o) begin
          state_nxt = (cmd_q == CMD_KEY) ? OUT : DATA_GO;
        end else if (tmo) begin
          state_nxt = OUT;
        end
      end
      DATA_GO: state_nxt = DATA_WAIT;
      DATA_WAIT: begin
        if (aes_en_o || tmo) begin
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (m_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready           = (state == IDLE) && reset;
    busy              = (state != IDLE);
    m_valid           = (state == OUT);
    aes_en            = (state == KEY_GO) || (state == DATA_GO);
    aes_key_exp_mode  = (state == KEY_GO) || (state == KEY_WAIT);
    aes_cipher_mode   = 1'b0;
    aes_decipher_mode = 1'b0;
    if ((state == DATA_GO) || (state == DATA_WAIT)) begin
      aes_cipher_mode   = (cmd_q == CMD_ENC);
      aes_decipher_mode = (cmd_q == CMD_DEC);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q      <= '0;
      key_q      <= '0;
      blk_q      <= '0;
      res_q      <= '0;
      status_q   <= '0;
      cached_key <= '0;
      key_valid  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            cmd_q    <= s_cmd;
            key_q    <= s_key;
            blk_q    <= s_blk;
            res_q    <= '0;
            status_q <= (s_cmd == CMD_RSV) ? ST_BAD : ST_OK;
          end
        end
        KEY_WAIT: begin
          if (aes_en_o) begin
            key_valid  <= 1'b1;
            cached_key <= key_q;
          end else if (tmo) begin
            key_valid <= 1'b0;
            status_q  <= ST_TMO;
            res_q     <= '0;
          end
        end
        DATA_WAIT: begin
          if (aes_en_o) begin
            res_q <= aes_out_blk;
          end else if (tmo) begin
            key_valid <= 1'b0;
            status_q  <= ST_TMO;
            res_q     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_blk      = res_q;
  assign m_status   = status_q;
  assign aes_key    = key_q;
  assign aes_in_blk = blk_q;

endmodule

// File: tb/tb_aes_cmd_sched.sv
// Scoreboard bench for aes_cmd_sched with a behavioural AES core stand-in.
// Exercises the timeout path only when AES_CMD_SCHED_TIMEOUT_EN is defined.
module tb_aes_cmd_sched;

  localparam int unsigned KW       = 128;
  localparam int unsigned BW       = 128;
  localparam int unsigned TO       = 16;
  localparam int unsigned CORE_DLY = 12;
  localparam logic [127:0] EXP_C   = 128'h5a5a_c3c3_0ff0_1234_a5a5_3c3c_f00f_9876;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [1:0]    s_cmd = '0;
  logic [KW-1:0] s_key = '0;
  logic [BW-1:0] s_blk = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [BW-1:0] m_blk;
  logic [1:0]    m_status;
  logic          aes_en, aes_cipher_mode, aes_decipher_mode, aes_key_exp_mode;
  logic [KW-1:0] aes_key;
  logic [BW-1:0] aes_in_blk;
  logic [BW-1:0] aes_out_blk;
  logic          aes_en_o;
  logic          busy;

  always #5 clk = ~clk;

  aes_cmd_sched #(
    .KEY_W(KW),
    .BLK_W(BW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_cmd(s_cmd),
    .s_key(s_key),
    .s_blk(s_blk),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_blk(m_blk),
    .m_status(m_status),
    .aes_en(aes_en),
    .aes_cipher_mode(aes_cipher_mode),
    .aes_decipher_mode(aes_decipher_mode),
    .aes_key_exp_mode(aes_key_exp_mode),
    .aes_key(aes_key),
    .aes_in_blk(aes_in_blk),
    .aes_out_blk(aes_out_blk),
    .aes_en_o(aes_en_o),
    .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Core stand-in: key expansion stores a derived key used by later cipher/decipher runs.
  logic          core_done, spur, mute;
  logic          run;
  int unsigned   dly;
  logic [2:0]    mode_l;
  logic [127:0]  key_l, blk_l, ek_m;
  assign aes_en_o = core_done | spur;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run       <= 1'b0;
      core_done <= 1'b0;
      dly       <= 0;
    end else begin
      core_done <= 1'b0;
      if (aes_en) begin
        run    <= 1'b1;
        dly    <= CORE_DLY;
        mode_l <= {aes_cipher_mode, aes_decipher_mode, aes_key_exp_mode};
        key_l  <= aes_key;
        blk_l  <= aes_in_blk;
      end else if (run) begin
        if (dly == 1) begin
          run <= 1'b0;
          if (!mute) begin
            core_done <= 1'b1;
            if (mode_l[0]) begin
              ek_m        <= key_l ^ EXP_C;
              aes_out_blk <= ~blk_l;
            end else if (mode_l[2]) begin
              aes_out_blk <= blk_l ^ ek_m;
            end else begin
              aes_out_blk <= blk_l - ek_m;
            end
          end
        end else begin
          dly <= dly - 1;
        end
      end
    end
  end

  int cyc = 0;
  int en_total = 0;
  int kx_total = 0;
  int last_en = -1;
  int last_done = -1;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (aes_en) begin
      en_total <= en_total + 1;
      last_en  <= cyc;
      if (aes_key_exp_mode) kx_total <= kx_total + 1;
    end
    if (aes_en_o) last_done <= cyc;
    if (core_done) begin
      check("mode_held", 128'({aes_cipher_mode, aes_decipher_mode, aes_key_exp_mode}), 128'(mode_l));
      check("key_held", aes_key, key_l);
    end
  end

  typedef struct {
    logic [127:0] blk;
    logic [1:0]   st;
    int           n_en;
    int           n_kx;
    int           en_base;
    int           kx_base;
    int           lat;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  logic         tb_kv = 1'b0;
  logic [127:0] tb_key = '0;
  logic [127:0] tb_ek = '0;

  task automatic issue(input logic [1:0] cmd, input logic [127:0] key, input logic [127:0] blk,
                       input bit to_exp);
    exp_t e;
    bit   need;
    int   n = 0;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("s_ready_idle", 128'(s_ready), 128'(1));
    need = !tb_kv || (key != tb_key);
    e.n_kx = 0;
    if (cmd == 2'b11) begin
      e.st = 2'b01; e.blk = '0; e.n_en = 0; e.lat = 2;
    end else if (cmd == 2'b10) begin
      e.st = 2'b00; e.blk = '0; e.n_en = 1; e.n_kx = 1; e.lat = 1;
      tb_kv = 1'b1; tb_key = key; tb_ek = key ^ EXP_C;
    end else begin
      if (need) begin
        e.n_kx = 1;
        tb_kv = 1'b1; tb_key = key; tb_ek = key ^ EXP_C;
      end
      e.n_en = e.n_kx + 1;
      e.st   = 2'b00;
      e.blk  = (cmd == 2'b00) ? (blk ^ tb_ek) : (blk - tb_ek);
      e.lat  = 1;
    end
    if (to_exp) begin
      e.st = 2'b10; e.blk = '0; e.n_en = 1; e.lat = 3;
      tb_kv = 1'b0;
    end
    s_valid   = 1'b1;
    s_cmd     = cmd;
    s_key     = key;
    s_blk     = blk;
    e.acc     = cyc;
    e.en_base = en_total;
    e.kx_base = kx_total;
    sb.push_back(e);
    @(negedge clk);
    s_valid = 1'b0;
    check("s_ready_busy", 128'(s_ready), 128'(0));
  endtask

  task automatic complete(input int hold);
    exp_t         e;
    int           n = 0;
    int           mv;
    logic [127:0] blk0;
    logic [1:0]   st0;
    while (!m_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("m_valid_seen", 128'(m_valid), 128'(1));
    mv = cyc;
    if (sb.size() == 0) begin
      check("sb_nonempty", 128'(0), 128'(1));
      return;
    end
    e = sb.pop_front();
    check("m_blk", m_blk, e.blk);
    check("m_status", 128'(m_status), 128'(e.st));
    check("n_aes_en", 128'(en_total - e.en_base), 128'(e.n_en));
    check("n_key_exp", 128'(kx_total - e.kx_base), 128'(e.n_kx));
    check("out_modes_off", 128'({aes_cipher_mode, aes_decipher_mode, aes_key_exp_mode}), 128'(0));
    case (e.lat)
      1: begin
        check("lat_after_done", 128'(mv), 128'(last_done + 1));
        if (e.n_en == 1) check("lat_en_after_acc", 128'(last_en), 128'(e.acc + 1));
      end
      2: check("lat_bad_cmd", 128'(mv), 128'(e.acc + 1));
      3: check("lat_timeout", 128'(mv), 128'(last_en + int'(TO) + 1));
      default: ;
    endcase
    blk0 = m_blk;
    st0  = m_status;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_m_valid", 128'(m_valid), 128'(1));
      check("hold_m_blk", m_blk, blk0);
      check("hold_m_status", 128'(m_status), 128'(st0));
      check("hold_s_ready", 128'(s_ready), 128'(0));
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("post_m_valid", 128'(m_valid), 128'(0));
    check("post_s_ready", 128'(s_ready), 128'(1));
  endtask

  task automatic do_cmd(input logic [1:0] cmd, input logic [127:0] key, input logic [127:0] blk,
                        input int hold);
    issue(cmd, key, blk, 1'b0);
    complete(hold);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_outs"},
          128'({s_ready, m_valid, aes_en, aes_cipher_mode, aes_decipher_mode, aes_key_exp_mode, busy}),
          128'(0));
    check({tag, "_key"}, aes_key, '0);
    check({tag, "_blk"}, aes_in_blk, '0);
    check({tag, "_m_blk"}, m_blk, '0);
    check({tag, "_m_status"}, 128'(m_status), 128'(0));
  endtask

  localparam logic [127:0] K1 = 128'h2b7e_1516_28ae_d2a6_abf7_1588_09cf_4f3c;
  localparam logic [127:0] K2 = 128'h0001_0203_0405_0607_0809_0a0b_0c0d_0e0f;
  localparam logic [127:0] K3 = 128'hdead_beef_cafe_f00d_1357_9bdf_2468_ace0;

  initial begin
    logic [127:0] keys [3];
    int           n;
    keys[0] = K1; keys[1] = K2; keys[2] = K3;
    spur = 1'b0;
    mute = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("s_ready_after_reset", 128'(s_ready), 128'(1));

    do_cmd(2'b00, K1, 128'h3243_f6a8_885a_308d_3131_98a2_e037_0734, 0);
    do_cmd(2'b00, K1, 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff, 0);
    do_cmd(2'b01, K2, 128'h6bc1_bee2_2e40_9f96_e93d_7e11_7393_172a, 0);
    do_cmd(2'b01, K2, 128'hae2d_8a57_1e03_ac9c_9eb7_6fac_45af_8e51, 0);
    do_cmd(2'b11, K2, 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000, 5);
    do_cmd(2'b00, K2, 128'h30c8_1c46_a35c_e411_e5fb_c119_1a0a_52ef, 0);
    do_cmd(2'b10, K1, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0);
    do_cmd(2'b00, K1, 128'hf69f_2445_df4f_9b17_ad2b_417b_e66c_3710, 0);

    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    check("spur_idle_m_valid", 128'(m_valid), 128'(0));
    check("spur_idle_busy", 128'(busy), 128'(0));
    check("spur_idle_s_ready", 128'(s_ready), 128'(1));

    for (int i = 0; i < 8; i++) begin
      do_cmd(2'($urandom_range(0, 3)), keys[$urandom_range(0, 2)],
             {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 2)));
    end

    // Abandon a command mid-run and confirm the key cache is forgotten.
    do_cmd(2'b00, K1, 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef, 0);
    issue(2'b00, K1, 128'h5555_aaaa_5555_aaaa_5555_aaaa_5555_aaaa, 1'b0);
    n = 0;
    while (!(aes_cipher_mode && !aes_en) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reached_data_wait", 128'(aes_cipher_mode && !aes_en), 128'(1));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_quiet("mid_reset");
    sb.delete();
    tb_kv = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_cmd(2'b00, K1, 128'h5555_aaaa_5555_aaaa_5555_aaaa_5555_aaaa, 0);

`ifdef AES_CMD_SCHED_TIMEOUT_EN
    mute = 1'b1;
    issue(2'b00, K3, 128'h7777_8888_9999_aaaa_bbbb_cccc_dddd_eeee, 1'b1);
    complete(0);
    mute = 1'b0;
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    check("late_done_m_valid", 128'(m_valid), 128'(0));
    check("late_done_busy", 128'(busy), 128'(0));
    do_cmd(2'b00, K3, 128'h7777_8888_9999_aaaa_bbbb_cccc_dddd_eeee, 0);
`endif

    check("sb_drained", 128'(sb.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/aes_cmd_sched.md
Name: aes_cmd_sched

Overview:
- Command sequencer in front of the AES core (key expansion, cipher, decipher engines sharing one round-key SRAM).
- Accepts one command at a time over a valid/ready input, drives the core's one-cycle enable and held mode selects, and waits for the core's done pulse.
- Returns results over a valid/ready output.
- Caches the last expanded key and re-runs key expansion only when the key changes.

Parameters:
- KEY_W, 128, key width (bits).
- BLK_W, 128, data block width (bits).
- TIMEOUT_CYCLES, 256, max cycles waiting for core done (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- s_valid  in  1  command valid.
- s_ready  out  1  command accepted when s_valid&&s_ready.
- s_cmd  in  2  00 encrypt, 01 decrypt, 10 key-load only, 11 reserved.
- s_key  in  KEY_W  key for this command.
- s_blk  in  BLK_W  input block (ignored for key-load).
- m_valid  out  1  result valid.
- m_ready  in  1  result consumed when m_valid&&m_ready.
- m_blk  out  BLK_W  result block (zero for key-load/error).
- m_status  out  2  00 ok, 01 bad command, 10 timeout.
- aes_en  out  1  one-cycle start pulse to core.
- aes_cipher_mode  out  1  core encrypt mode select.
- aes_decipher_mode  out  1  core decrypt mode select.
- aes_key_exp_mode  out  1  core key-expansion mode select.
- aes_key  out  KEY_W  key to core (registered copy).
- aes_in_blk  out  BLK_W  block to core (registered copy).
- aes_out_blk  in  BLK_W  core result.
- aes_en_o  in  1  core done pulse.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, async):
  - State = IDLE; key_valid = 0; cached key cleared.
  - All outputs 0, except s_ready, which is 1 once reset deasserts.
- States and transitions:
  - IDLE: s_ready=1. On accept, latch cmd/key/blk into registers.
    - cmd 11 → OUT with status 01; no core activity.
    - cmd 10, or cmd 00/01 with (!key_valid || s_key != cached key) → KEY_GO.
    - Otherwise → DATA_GO.
  - KEY_GO: aes_key_exp_mode=1, aes_en=1 for exactly this cycle → KEY_WAIT.
  - KEY_WAIT: aes_key_exp_mode held 1. On aes_en_o:
    - key_valid=1; cached key = latched key.
    - cmd 10 → OUT with status 00, m_blk=0.
    - Otherwise → DATA_GO.
  - DATA_GO: matching mode select = 1 (cipher for 00, decipher for 01), aes_en=1 for exactly this cycle → DATA_WAIT.
  - DATA_WAIT: mode held. On aes_en_o, capture aes_out_blk into m_blk, status 00 → OUT.
  - OUT: m_valid=1, all mode selects 0. m_blk/m_status stable until m_ready. On m_valid&&m_ready → IDLE.
- Exactly one mode select is high in GO/WAIT states; all are 0 in IDLE and OUT. Mode never changes while the core is running.
- aes_key/aes_in_blk are stable from GO until leaving WAIT.
- aes_en_o outside a WAIT state is ignored.
- Latency, cached key: accept at cycle T, aes_en at T+1, m_valid at the cycle after aes_en_o.
- Latency, new key: as above, plus one full key-expansion round trip and one extra GO cycle.
- s_ready=0 from accept until return to IDLE. No back-to-back accept in the cycle OUT completes; s_ready rises the following cycle.
- Reset mid-operation:
  - Abandons the command with no output; key_valid cleared.
  - The core's own reset is separate; the scheduler does not wait for it.
- Key compare is full KEY_W equality. An identical key after a completed key-load issues no key expansion.

Optional Feature:
- Macro: AES_CMD_SCHED_TIMEOUT_EN.
- With the macro:
  - A counter clears on entering KEY_WAIT/DATA_WAIT and increments each cycle there.
  - If it reaches TIMEOUT_CYCLES without aes_en_o: → OUT, status 10, m_blk=0, key_valid=0.
  - A late aes_en_o is then ignored.
- Without the macro: no counter; WAIT states hold indefinitely; status 10 never produced.

Test Plan:
- After reset, cmd 00, key K1, blk P (core model done 12 cycles after en) → aes_key_exp_mode pulse sequence, then cipher; m_blk = model output, status 00; exactly 2 aes_en pulses.
- Repeat cmd 00 with K1 → exactly 1 aes_en (cipher), no key expansion; m_valid the cycle after aes_en_o.
- cmd 01 with K2 → key expansion then decipher; cached key becomes K2; next cmd 01 with K2 issues 1 aes_en.
- cmd 11 → m_valid 1 cycle after accept, status 01, no aes_en. Hold m_ready=0 for 5 cycles → m_blk/m_status stable, s_ready=0.
- Reset low during DATA_WAIT → outputs 0 immediately; next cmd 00 with same key re-runs key expansion.
- With AES_CMD_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, core never signals done → status 10 after 16 WAIT cycles, key_valid cleared; spurious later aes_en_o ignored.
